// File: rtl/merge_pkg.sv
// rtl/merge_pkg.sv - shared types, defaults and counter widths for the two-run merge layer
package merge_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int RUN_LEN_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // per-side consumed counter must hold the value RUN_LEN itself
    function automatic int cnt_w(input int run_len);
        return $clog2(run_len + 1);
    endfunction

    function automatic int out_w(input int run_len);
        return $clog2(2 * run_len + 1);
    endfunction

endpackage

// File: rtl/merge_cmp.sv
// rtl/merge_cmp.sv - key comparator choosing side A or B; ties go to A so the merge is stable
module merge_cmp #(
    parameter int DATA_W = merge_pkg::DATA_W_DEF
) (
    input  logic [DATA_W-1:0] key_a,
    input  logic [DATA_W-1:0] key_b,
    input  logic              descend,
    output logic              take_a
);

    assign take_a = descend ? (key_a >= key_b) : (key_a <= key_b);

endmodule

// File: rtl/merge_layer_2_1.sv
// rtl/merge_layer_2_1.sv - merges two sorted runs of RUN_LEN keys into one registered output stream
module merge_layer_2_1
    import merge_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RUN_LEN = RUN_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              descend,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [DATA_W-1:0] b_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    localparam int CW = cnt_w(RUN_LEN);
    localparam int OW = out_w(RUN_LEN);
    localparam logic [CW-1:0] LP_RUN  = CW'(RUN_LEN);
    localparam logic [OW-1:0] LP_LAST = OW'(2 * RUN_LEN - 1);

    state_t            r_state;
    logic              r_desc;
    logic [DATA_W-1:0] r_a_head;
    logic [DATA_W-1:0] r_b_head;
    logic              r_a_hv;
    logic              r_b_hv;
    logic [CW-1:0]     r_a_cons;
    logic [CW-1:0]     r_b_cons;
    logic [OW-1:0]     r_out_cnt;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic              r_m_last;

    logic              w_take_a;
    logic              w_a_done;
    logic              w_b_done;
    logic              w_sel_valid;
    logic              w_sel_a;
    logic              w_load;
    logic              w_a_ready;
    logic              w_b_ready;
    logic              w_m_hs;

    merge_cmp #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .key_a   (r_a_head),
        .key_b   (r_b_head),
        .descend (r_desc),
        .take_a  (w_take_a)
    );

    assign w_a_done = (r_a_cons == LP_RUN);
    assign w_b_done = (r_b_cons == LP_RUN);

    // once a side has emitted its whole run the other side drains without comparing
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_a     = 1'b0;
        if (w_a_done) begin
            w_sel_valid = r_b_hv;
            w_sel_a     = 1'b0;
        end else if (w_b_done) begin
            w_sel_valid = r_a_hv;
            w_sel_a     = 1'b1;
        end else begin
            w_sel_valid = r_a_hv && r_b_hv;
            w_sel_a     = w_take_a;
        end
    end

    assign w_load    = (r_state == ST_RUN) && w_sel_valid && (!r_m_valid || m_ready);
    assign w_m_hs    = r_m_valid && m_ready;
    assign w_a_ready = (r_state == ST_RUN) && !r_a_hv && !w_a_done;
    assign w_b_ready = (r_state == ST_RUN) && !r_b_hv && !w_b_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_desc    <= 1'b0;
            r_a_head  <= '0;
            r_b_head  <= '0;
            r_a_hv    <= 1'b0;
            r_b_hv    <= 1'b0;
            r_a_cons  <= '0;
            r_b_cons  <= '0;
            r_out_cnt <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
        end else if (abort) begin
            r_state   <= ST_IDLE;
            r_desc    <= 1'b0;
            r_a_head  <= '0;
            r_b_head  <= '0;
            r_a_hv    <= 1'b0;
            r_b_hv    <= 1'b0;
            r_a_cons  <= '0;
            r_b_cons  <= '0;
            r_out_cnt <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_RUN;
                        r_desc    <= descend;
                        r_a_hv    <= 1'b0;
                        r_b_hv    <= 1'b0;
                        r_a_cons  <= '0;
                        r_b_cons  <= '0;
                        r_out_cnt <= '0;
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (a_valid && w_a_ready) begin
                        r_a_head <= a_data;
                        r_a_hv   <= 1'b1;
                    end
                    if (b_valid && w_b_ready) begin
                        r_b_head <= b_data;
                        r_b_hv   <= 1'b1;
                    end
                    // a head is only ever cleared while full and only filled while empty
                    if (w_load) begin
                        r_m_valid <= 1'b1;
                        r_m_last  <= (r_out_cnt == LP_LAST);
                        r_out_cnt <= r_out_cnt + OW'(1);
                        if (w_sel_a) begin
                            r_m_data <= r_a_head;
                            r_a_hv   <= 1'b0;
                            r_a_cons <= r_a_cons + CW'(1);
                        end else begin
                            r_m_data <= r_b_head;
                            r_b_hv   <= 1'b0;
                            r_b_cons <= r_b_cons + CW'(1);
                        end
                    end else if (w_m_hs) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                    end
                    if (w_m_hs && r_m_last) begin
                        r_state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign a_ready = w_a_ready;
    assign b_ready = w_b_ready;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_last  = r_m_last;
    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_FIN);

endmodule

// File: tb/tb_merge_layer_2_1.sv
// tb/tb_merge_layer_2_1.sv - directed bench for the two-run merge layer with RUN_LEN=4, DATA_W=16
module tb_merge_layer_2_1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        descend;
    logic        a_valid;
    logic        a_ready;
    logic [15:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [15:0] b_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] ta [4];
    logic [15:0] tb [4];
    logic [15:0] te [8];
    logic        ts [8];

    merge_layer_2_1 #(
        .DATA_W  (16),
        .RUN_LEN (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .descend (descend),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_data  (b_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk(32'(busy),    32'd0, {tag, "_busy"});
        chk(32'(done),    32'd0, {tag, "_done"});
        chk(32'(m_valid), 32'd0, {tag, "_m_valid"});
        chk(32'(m_last),  32'd0, {tag, "_m_last"});
        chk(32'(m_data),  32'd0, {tag, "_m_data"});
        chk(32'(a_ready), 32'd0, {tag, "_a_ready"});
        chk(32'(b_ready), 32'd0, {tag, "_b_ready"});
    endtask

    // Drives one job from ta/tb, checks outputs against te (and sources against ts), stops after stop_at outputs.
    task automatic run_job(input logic desc, input bit rnd, input int stop_at, input bit chk_src, input string tag);
        int          ai;
        int          bi;
        int          oi;
        logic [15:0] held;
        bit          stalled;
        logic [2:0]  pa;
        bit          done_seen;
        ai = 0; bi = 0; oi = 0; stalled = 0; pa = 3'd0; done_seen = 0; held = 16'h0;
        @(posedge clk); #1;
        start = 1'b1; descend = desc;
        @(posedge clk); #1;
        start = 1'b0; descend = 1'b0;
        for (int cyc = 0; cyc < 400 && oi < stop_at; cyc++) begin
            a_valid = (ai < 4) && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
            a_data  = (ai < 4) ? ta[ai[1:0]] : 16'h0;
            b_valid = (bi < 4) && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
            b_data  = (bi < 4) ? tb[bi[1:0]] : 16'h0;
            m_ready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            @(negedge clk);
            if (done) done_seen = 1;
            if (stalled) begin
                chk(32'(m_valid), 32'd1, {tag, "_hold_valid"});
                chk(32'(m_data), 32'(held), {tag, "_hold_data"});
            end
            if (a_valid && a_ready) ai++;
            if (b_valid && b_ready) bi++;
            if (m_valid && m_ready) begin
                chk(32'(m_data), 32'(te[oi[2:0]]), $sformatf("%s_data%0d", tag, oi));
                chk(32'(m_last), (oi == 7) ? 32'd1 : 32'd0, $sformatf("%s_last%0d", tag, oi));
                if (chk_src) begin
                    chk((dut.r_a_cons != pa) ? 32'd1 : 32'd0, 32'(ts[oi[2:0]]), $sformatf("%s_src%0d", tag, oi));
                end
                pa = dut.r_a_cons;
                oi++;
                stalled = 0;
            end else if (m_valid) begin
                stalled = 1;
                held = m_data;
            end else begin
                stalled = 0;
            end
            @(posedge clk); #1;
        end
        a_valid = 1'b0; b_valid = 1'b0; m_ready = 1'b1;
        chk(32'(oi), 32'(stop_at), {tag, "_count"});
        if (stop_at == 8) begin
            chk(32'(done_seen), 32'd0, {tag, "_done_early"});
            chk(32'(done), 32'd1, {tag, "_done_pulse"});
            @(posedge clk); #1;
            chk(32'(done), 32'd0, {tag, "_done_width"});
            chk(32'(busy), 32'd0, {tag, "_idle_after"});
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; descend = 1'b0;
        a_valid = 1'b0; a_data = 16'h0; b_valid = 1'b0; b_data = 16'h0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1;
        @(posedge clk); #1;
        chk(32'(a_ready), 32'd0, "idle_a_ready");
        chk(32'(busy),    32'd0, "idle_busy");
        a_valid = 1'b0; b_valid = 1'b0;

        ta = '{16'd1, 16'd3, 16'd5, 16'd7};
        tb = '{16'd2, 16'd4, 16'd6, 16'd8};
        te = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        run_job(1'b0, 1'b0, 8, 1'b0, "interleave");

        ta = '{16'd1, 16'd2, 16'd3, 16'd4};
        tb = '{16'd5, 16'd6, 16'd7, 16'd8};
        ts = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        run_job(1'b0, 1'b0, 8, 1'b1, "drain_b");

        ta = '{16'd5, 16'd5, 16'd9, 16'd9};
        tb = '{16'd5, 16'd9, 16'd9, 16'd9};
        te = '{16'd5, 16'd5, 16'd5, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9};
        ts = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        run_job(1'b0, 1'b0, 8, 1'b1, "ties");

        ta = '{16'd9, 16'd6, 16'd3, 16'd0};
        tb = '{16'd8, 16'd7, 16'd2, 16'd1};
        te = '{16'd9, 16'd8, 16'd7, 16'd6, 16'd3, 16'd2, 16'd1, 16'd0};
        run_job(1'b1, 1'b0, 8, 1'b0, "descend");

        ta = '{16'd1, 16'd3, 16'd5, 16'd7};
        tb = '{16'd2, 16'd4, 16'd6, 16'd8};
        te = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        run_job(1'b0, 1'b1, 8, 1'b0, "stall");
        run_job(1'b0, 1'b1, 8, 1'b0, "stall2");

        run_job(1'b0, 1'b0, 3, 1'b0, "abort_part");
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk_idle_outputs("abort");
        @(posedge clk); #1;
        chk(32'(done), 32'd0, "abort_no_done");
        run_job(1'b0, 1'b0, 8, 1'b0, "after_abort");

        run_job(1'b0, 1'b0, 3, 1'b0, "rst_part");
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk(32'(done), 32'd0, "rst_no_done");
        ta = '{16'd1, 16'd2, 16'd3, 16'd4};
        tb = '{16'd5, 16'd6, 16'd7, 16'd8};
        run_job(1'b0, 1'b0, 8, 1'b0, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/merge_layer_2_1.md
MERGE_LAYER_2_1 -- requirements
Module: merge_layer_2_1

Interface
REQ-001 Parameter DATA_W, default 16, width of each sort key (unsigned).
REQ-002 Parameter RUN_LEN, default 4, length of each sorted input run; legal range 1..256.
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port start  input  1  single-cycle pulse that begins one merge job; honoured only in IDLE.
REQ-006 Port abort  input  1  synchronous clear to IDLE; no done pulse.
REQ-007 Port descend  input  1  order select (0 ascending, 1 descending); sampled on accepted start.
REQ-008 Port a_valid/a_ready/a_data  in/out/in  1/1/DATA_W  run A stream, already sorted in the selected order.
REQ-009 Port b_valid/b_ready/b_data  in/out/in  1/1/DATA_W  run B stream, already sorted in the selected order.
REQ-010 Port m_valid/m_ready/m_data/m_last  out/in/out/out  1/1/DATA_W/1  merged output stream; m_last marks element 2*RUN_LEN.
REQ-011 Port busy  output  1  high in every state other than IDLE.
REQ-012 Port done  output  1  one-cycle pulse on job completion.

Function
REQ-013 States: IDLE, RUN, FIN. IDLE->RUN on start; RUN->FIN on the handshake of the m_last element; FIN->IDLE unconditionally after one cycle; any state->IDLE on abort.
REQ-014 done is asserted only in FIN, so it rises the cycle after the final m handshake and lasts exactly one cycle.
REQ-015 Each side has a head register plus a head-valid flag; an input beat transfers when valid and ready are both high.
REQ-016 a_ready is high only in RUN, with head A empty and fewer than RUN_LEN A beats accepted in this job; b_ready follows the same rule for side B. No combinational path exists from m_ready to a_ready/b_ready.
REQ-017 Per-side consumed counters count elements emitted from A and B, each $clog2(RUN_LEN+1) bits wide; the output counter is $clog2(2*RUN_LEN+1) bits wide. All counters clear on start and on abort.
REQ-018 Selection when both heads are valid: ascending emits the smaller key, descending emits the larger key; on equal keys A is emitted (stable merge).
REQ-019 If one side's consumed count equals RUN_LEN, the other side's head is emitted with no compare (drain).
REQ-020 The output register loads when a selection is available and (m_valid==0 or m_ready==1); loading clears the chosen head-valid flag.
REQ-021 m_data, m_valid and m_last are registered; m_data and m_last stay stable while m_valid=1 and m_ready=0.
REQ-022 Throughput: at most one element per two cycles per side; one element per cycle overall when heads alternate.
REQ-023 start in RUN or FIN is ignored; a_valid/b_valid outside RUN are ignored.
REQ-024 RUN_LEN=1 is legal: one compare, one drain, then m_last.

Reset
REQ-025 On rst_n low: state=IDLE; busy=0, done=0, m_valid=0, m_last=0, m_data=0, a_ready=0, b_ready=0; all counters, head flags and the latched descend cleared.
REQ-026 abort applies the same values synchronously, and any in-flight m_valid is dropped.

Structure
REQ-027 Package merge_pkg holds the state enum, the DATA_W and RUN_LEN defaults, and the counter-width functions.
REQ-028 Sub-module merge_cmp (combinational): inputs key_a, key_b, descend; output take_a implementing REQ-018 including the tie rule.

Verification
REQ-029 RUN_LEN=4, ascending, A={1,3,5,7}, B={2,4,6,8}, m_ready=1 -> m_data 1..8, m_last with 8, done one cycle later.
REQ-030 A={1,2,3,4}, B={5,6,7,8} -> A emptied first, B drained with no compare; output 1..8.
REQ-031 Ties A={5,5,9,9}, B={5,9,9,9} -> 5,5,5,9,9,9,9,9 with the A element preceding the equal B element each time (check via traced source).
REQ-032 descend=1, A={9,6,3,0}, B={8,7,2,1} -> 9,8,7,6,3,2,1,0.
REQ-033 m_ready toggled randomly; source valids gapped -> same sequence, m_data held stable while stalled, no loss or duplication.
REQ-034 rst_n or abort asserted after 3 outputs -> all outputs at reset values next cycle, no done; a fresh start then merges correctly.
